// File: rtl/imem_load_ctrl.sv
// Instruction-memory port arbiter: CPU fetch pass-through, or byte-stream program load.
// Optional running word checksum enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_load_ctrl #(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic [15:0] load_words,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic [31:0] cpu_pc,
  output logic        cpu_hold,
  output logic [31:0] mem_A,
  output logic        mem_we,
  output logic [31:0] mem_data,
  output logic        load_busy,
  output logic        load_done,
  output logic        overflow,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] word;
  logic [31:0] widx;
  logic [31:0] waddr;
  logic        in_range;

  assign widx     = (BASE_ADDR >> 2) + {16'b0, word_cnt};
  assign in_range = widx < DEPTH;
  assign waddr    = BASE_ADDR + {14'b0, word_cnt, 2'b00};

  // The port belongs to the loader only in WRITE; otherwise fetch passes straight through.
  assign mem_A    = (state == WRITE) ? waddr : cpu_pc;
  assign mem_data = word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len        <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      word       <= '0;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b0;
      mem_we     <= 1'b0;
      load_busy  <= 1'b0;
      load_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_start) begin
            overflow <= 1'b0;
            cpu_hold <= 1'b1;
            if (load_words == '0) begin
              state     <= DONE;
              load_done <= 1'b1;
            end else begin
              state      <= RECV;
              len        <= load_words;
              word_cnt   <= '0;
              byte_cnt   <= '0;
              byte_ready <= 1'b1;
              load_busy  <= 1'b1;
            end
          end
        end
        RECV: begin
          if (byte_valid && byte_ready) begin
            word[{byte_cnt, 3'b000} +: 8] <= byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              mem_we     <= in_range;
            end
          end
        end
        WRITE: begin
          mem_we   <= 1'b0;
          word_cnt <= word_cnt + 16'd1;
          if (!in_range) overflow <= 1'b1;
          if (word_cnt + 16'd1 == len) begin
            state     <= DONE;
            load_busy <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state      <= RECV;
            byte_ready <= 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          load_done <= 1'b0;
          cpu_hold  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] sum;

  // Suppressed overflow words are still summed so the host can verify the whole stream.
  always_ff @(posedge clk) begin
    if (reset)
      sum <= '0;
    else if (state == IDLE && load_start)
      sum <= '0;
    else if (state == WRITE)
      sum <= sum + word;
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: a cycle table for the basic load plus
// hand sequences; a DEPTH=4 instance shares the stimulus for the overflow case.
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic [15:0] load_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [31:0] cpu_pc;

  logic        byte_ready, cpu_hold, mem_we, load_busy, load_done, overflow;
  logic [31:0] mem_A, mem_data, checksum;
  logic        byte_ready4, cpu_hold4, mem_we4, load_busy4, load_done4, overflow4;
  logic [31:0] mem_A4, mem_data4, checksum4;

  imem_load_ctrl #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_words(load_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .cpu_pc(cpu_pc), .cpu_hold(cpu_hold), .mem_A(mem_A), .mem_we(mem_we),
    .mem_data(mem_data), .load_busy(load_busy), .load_done(load_done),
    .overflow(overflow), .checksum(checksum)
  );

  imem_load_ctrl #(.DEPTH(4), .BASE_ADDR(32'h0)) dut4 (
    .clk(clk), .reset(reset), .load_start(load_start), .load_words(load_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready4),
    .cpu_pc(cpu_pc), .cpu_hold(cpu_hold4), .mem_A(mem_A4), .mem_we(mem_we4),
    .mem_data(mem_data4), .load_busy(load_busy4), .load_done(load_done4),
    .overflow(overflow4), .checksum(checksum4)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ready_drop = 0;

  // Write/done scoreboard, sampled mid-cycle.
  logic [31:0] wa[$], wd[$], wa4[$], wd4[$];
  int done_n = 0, done4_n = 0;

  always @(negedge clk) begin
    if (mem_we)  begin wa.push_back(mem_A);   wd.push_back(mem_data);   end
    if (mem_we4) begin wa4.push_back(mem_A4); wd4.push_back(mem_data4); end
    if (load_done)  done_n++;
    if (load_done4) done4_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete(); wd.delete(); wa4.delete(); wd4.delete();
    done_n = 0; done4_n = 0; ready_drop = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_load(input logic [15:0] n);
    @(posedge clk); #1;
    load_start = 1'b1; load_words = n;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Entered and left at posedge+1; holds the byte until the controller takes it.
  task automatic feed(input logic [7:0] b, input bit gap);
    bit taken = 1'b0;
    byte_valid = 1'b1; byte_data = b;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (byte_ready) begin taken = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!taken) check("feed_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
    if (gap) begin
      @(negedge clk);
      if (load_busy && !mem_we && !byte_ready) ready_drop++;
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] exp_sum(input logic [31:0] s);
`ifdef IMEM_LOAD_CHECKSUM_EN
    return s;
`else
    return 32'h0;
`endif
  endfunction

  typedef struct {
    logic        ls;
    logic [15:0] lw;
    logic        bv;
    logic [7:0]  bd;
    logic [31:0] pc;
    logic [4:0]  fl;   // {byte_ready, cpu_hold, mem_we, load_busy, load_done}
    logic [31:0] a;
    logic [31:0] d;
  } vec_t;

  vec_t vt[13];
  logic [7:0]  ob[24];
  logic [31:0] ow[6];
  logic [31:0] osum;

  initial begin
    vt[0]  = '{1'b1, 16'd2, 1'b0, 8'h00, 32'h10, 5'b00000, 32'h10, 32'h0};
    vt[1]  = '{1'b0, 16'd0, 1'b1, 8'h78, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[2]  = '{1'b1, 16'd7, 1'b1, 8'h56, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[3]  = '{1'b0, 16'd0, 1'b1, 8'h34, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[4]  = '{1'b0, 16'd0, 1'b1, 8'h12, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[5]  = '{1'b0, 16'd0, 1'b1, 8'hEF, 32'h10, 5'b01110, 32'h0,  32'h12345678};
    vt[6]  = '{1'b0, 16'd0, 1'b1, 8'hEF, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[7]  = '{1'b0, 16'd0, 1'b1, 8'hBE, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[8]  = '{1'b0, 16'd0, 1'b1, 8'hAD, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[9]  = '{1'b0, 16'd0, 1'b1, 8'hDE, 32'h10, 5'b11010, 32'h10, 32'h0};
    vt[10] = '{1'b0, 16'd0, 1'b0, 8'h00, 32'h10, 5'b01110, 32'h4,  32'hDEADBEEF};
    vt[11] = '{1'b0, 16'd0, 1'b0, 8'h00, 32'h20, 5'b01001, 32'h20, 32'h0};
    vt[12] = '{1'b0, 16'd0, 1'b0, 8'h00, 32'h24, 5'b00000, 32'h24, 32'h0};

    reset = 1'b1; load_start = 1'b0; load_words = '0;
    byte_valid = 1'b0; byte_data = '0; cpu_pc = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {27'b0, byte_ready, cpu_hold, mem_we, load_busy, load_done}, 32'h0);
    check("rst_A", mem_A, 32'h10);
    check("rst_ovf_sum", {overflow, checksum[30:0]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic two-word load, one table row per cycle.
    clear_log();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      load_start = vt[i].ls; load_words = vt[i].lw;
      byte_valid = vt[i].bv; byte_data = vt[i].bd; cpu_pc = vt[i].pc;
      @(negedge clk);
      check($sformatf("v%0d_flags", i),
            {27'b0, byte_ready, cpu_hold, mem_we, load_busy, load_done}, {27'b0, vt[i].fl});
      if (!(vt[i].fl[1] && !vt[i].fl[2])) check($sformatf("v%0d_A", i), mem_A, vt[i].a);
      if (vt[i].fl[2]) check($sformatf("v%0d_data", i), mem_data, vt[i].d);
    end
    load_start = 1'b0; byte_valid = 1'b0; cpu_pc = 32'h10;
    idle(2);
    check("t1_nwr", 32'(wa.size()), 32'd2);
    check("t1_done", 32'(done_n), 32'd1);
    check("t1_sum", checksum, exp_sum(32'h12345678 + 32'hDEADBEEF));
    check("t1_ovf", {31'b0, overflow}, 32'd0);

    // Same load with byte_valid toggling.
    clear_log();
    start_load(16'd2);
    feed(8'h78, 1'b1); feed(8'h56, 1'b1); feed(8'h34, 1'b1); feed(8'h12, 1'b1);
    feed(8'hEF, 1'b1); feed(8'hBE, 1'b1); feed(8'hAD, 1'b1); feed(8'hDE, 1'b1);
    idle(4);
    check("t2_nwr", 32'(wa.size()), 32'd2);
    check("t2_a0", wa[0], 32'h0);
    check("t2_d0", wd[0], 32'h12345678);
    check("t2_a1", wa[1], 32'h4);
    check("t2_d1", wd[1], 32'hDEADBEEF);
    check("t2_ready", 32'(ready_drop), 32'd0);
    check("t2_done", 32'(done_n), 32'd1);

    // Six words: DEPTH=4 instance must suppress the last two.
    clear_log();
    osum = '0;
    for (int i = 0; i < 24; i++) ob[i] = 8'(i * 7 + 1);
    for (int k = 0; k < 6; k++) begin
      ow[k] = {ob[4*k+3], ob[4*k+2], ob[4*k+1], ob[4*k]};
      osum  = osum + ow[k];
    end
    start_load(16'd6);
    for (int i = 0; i < 24; i++) feed(ob[i], 1'b0);
    idle(4);
    check("t3_nwr4", 32'(wa4.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t3_a4_%0d", k), wa4[k], 32'(4 * k));
      check($sformatf("t3_d4_%0d", k), wd4[k], ow[k]);
    end
    check("t3_ovf4", {31'b0, overflow4}, 32'd1);
    check("t3_done4", 32'(done4_n), 32'd1);
    check("t3_sum4", checksum4, exp_sum(osum));
    check("t3_nwr", 32'(wa.size()), 32'd6);
    check("t3_a5", wa[5], 32'h14);
    check("t3_ovf", {31'b0, overflow}, 32'd0);

    // Reset after six of eight bytes.
    clear_log();
    start_load(16'd2);
    feed(8'h11, 1'b0); feed(8'h22, 1'b0); feed(8'h33, 1'b0);
    feed(8'h44, 1'b0); feed(8'h55, 1'b0); feed(8'h66, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_flags", {27'b0, byte_ready, cpu_hold, mem_we, load_busy, load_done}, 32'h0);
    check("t4_ovf4", {31'b0, overflow4}, 32'd0);
    idle(3);
    check("t4_nwr", 32'(wa.size()), 32'd1);
    check("t4_d0", wd[0], 32'h44332211);
    check("t4_done", 32'(done_n), 32'd0);
    clear_log();
    start_load(16'd1);
    feed(8'hA1, 1'b0); feed(8'hB2, 1'b0); feed(8'hC3, 1'b0); feed(8'hD4, 1'b0);
    idle(4);
    check("t4_rl_nwr", 32'(wa.size()), 32'd1);
    check("t4_rl_a", wa[0], 32'h0);
    check("t4_rl_d", wd[0], 32'hD4C3B2A1);
    check("t4_rl_done", 32'(done_n), 32'd1);

    // Zero-length load.
    clear_log();
    @(posedge clk); #1;
    load_start = 1'b1; load_words = 16'd0;
    @(posedge clk); #1;
    load_start = 1'b0;
    @(negedge clk);
    check("t5_done_cyc", {27'b0, byte_ready, cpu_hold, mem_we, load_busy, load_done}, 32'b01001);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_idle_cyc", {27'b0, byte_ready, cpu_hold, mem_we, load_busy, load_done}, 32'b00000);
    idle(2);
    check("t5_nwr", 32'(wa.size() + wa4.size()), 32'd0);
    check("t5_done", 32'(done_n), 32'd1);
    check("t5_sum", checksum, 32'h0);

    // load_start during RECV must not restart or extend the load.
    clear_log();
    start_load(16'd1);
    feed(8'h01, 1'b0); feed(8'h02, 1'b0);
    load_start = 1'b1; load_words = 16'd5;
    @(negedge clk);
    check("t6_in_recv", {31'b0, load_busy}, 32'd1);
    @(posedge clk); #1;
    load_start = 1'b0;
    feed(8'h03, 1'b0); feed(8'h04, 1'b0);
    idle(5);
    @(negedge clk);
    check("t6_busy", {31'b0, load_busy}, 32'd0);
    check("t6_nwr", 32'(wa.size()), 32'd1);
    check("t6_d0", wd[0], 32'h04030201);
    check("t6_done", 32'(done_n), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
